// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multicycle RV32I-subset datapath: FSM states, opcode/funct
// encodings, ALU operations and the instruction class decoder.
package multicycle_datapath_pkg;

    localparam int unsigned NumRegs = 32;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluSlt
    } alu_op_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsHalt
    } instr_cls_e;

    localparam logic [6:0] OpcReg    = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Word   = 3'b010;
    localparam logic [2:0] F3Beq    = 3'b000;
    localparam logic [2:0] F3Bne    = 3'b001;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    typedef struct packed {
        instr_cls_e cls;
        alu_op_e    alu_op;
    } dec_t;

    // Anything not explicitly recognised (including ecall) classifies as ClsHalt.
    function automatic dec_t decode_instr(input logic [31:0] ir);
        dec_t d;
        d.cls    = ClsHalt;
        d.alu_op = AluAdd;
        case (ir[6:0])
            OpcReg: begin
                if (ir[31:25] == F7Base) begin
                    case (ir[14:12])
                        F3AddSub: begin d.cls = ClsAlu; d.alu_op = AluAdd; end
                        F3Slt:    begin d.cls = ClsAlu; d.alu_op = AluSlt; end
                        F3And:    begin d.cls = ClsAlu; d.alu_op = AluAnd; end
                        F3Or:     begin d.cls = ClsAlu; d.alu_op = AluOr;  end
                        default:  d.cls = ClsHalt;
                    endcase
                end else if (ir[31:25] == F7Alt && ir[14:12] == F3AddSub) begin
                    d.cls    = ClsAlu;
                    d.alu_op = AluSub;
                end
            end
            OpcImm:    if (ir[14:12] == F3AddSub) d.cls = ClsAlu;
            OpcLoad:   if (ir[14:12] == F3Word) d.cls = ClsLoad;
            OpcStore:  if (ir[14:12] == F3Word) d.cls = ClsStore;
            OpcBranch: if (ir[14:12] == F3Beq || ir[14:12] == F3Bne) d.cls = ClsBranch;
            default:   d.cls = ClsHalt;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32 x XLEN register file: two combinational read ports, one synchronous write port.
// x0 reads as zero and ignores writes.
module riscv_regfile
    import multicycle_datapath_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    logic [XLEN-1:0] r_regs [NumRegs];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && i_waddr != 5'd0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I-subset core (add/sub/and/or/slt/addi/lw/sw/beq/bne) on a single
// unified memory port; FETCH/DECODE/EXEC/MEM/WB/HALT sequencing.
module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halt
);

    state_e          r_state, w_state_d;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_alu, r_mdr;

    dec_t            w_dec;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm, w_op_b, w_alu_res, w_pc_next, w_wb_data;
    logic            w_taken, w_lt, w_req, w_we, w_retire, w_rf_we;
    logic [XLEN-1:0] w_addr;

    assign w_dec = decode_instr(r_ir);

    riscv_regfile #(
        .XLEN (XLEN)
    ) u_regfile (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_raddr1 (r_ir[19:15]),
        .i_raddr2 (r_ir[24:20]),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data),
        .i_we     (w_rf_we),
        .i_waddr  (r_ir[11:7]),
        .i_wdata  (w_wb_data)
    );

    always_comb begin
        w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
        if (r_ir[6:0] == OpcStore) begin
            w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        end else if (r_ir[6:0] == OpcBranch) begin
            w_imm = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        end
    end

    assign w_op_b = (r_ir[6:0] == OpcReg) ? r_b : r_imm;
    assign w_lt   = $signed(r_a) < $signed(w_op_b);

    always_comb begin
        w_alu_res = r_a + w_op_b;
        unique case (w_dec.alu_op)
            AluAdd:  w_alu_res = r_a + w_op_b;
            AluSub:  w_alu_res = r_a - w_op_b;
            AluAnd:  w_alu_res = r_a & w_op_b;
            AluOr:   w_alu_res = r_a | w_op_b;
            AluSlt:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt};
            default: w_alu_res = r_a + w_op_b;
        endcase
    end

    assign w_taken   = (r_ir[14:12] == F3Bne) ? (r_a != r_b) : (r_a == r_b);
    assign w_pc_next = (r_state == StExec && w_dec.cls == ClsBranch && w_taken)
                     ? r_pc + r_imm : r_pc + XLEN'(4);
    assign w_wb_data = (w_dec.cls == ClsLoad) ? r_mdr : r_alu;
    assign w_rf_we   = (r_state == StWb) && !reset;

    always_comb begin
        w_state_d = r_state;
        w_req     = 1'b0;
        w_we      = 1'b0;
        w_addr    = r_pc;
        w_retire  = 1'b0;
        unique case (r_state)
            StFetch: begin
                w_req = 1'b1;
                if (mem_ready) w_state_d = StDecode;
            end
            StDecode: w_state_d = StExec;
            StExec: begin
                unique case (w_dec.cls)
                    ClsAlu:             w_state_d = StWb;
                    ClsLoad, ClsStore:  w_state_d = StMem;
                    ClsBranch: begin
                        w_state_d = StFetch;
                        w_retire  = 1'b1;
                    end
                    default:            w_state_d = StHalt;
                endcase
            end
            StMem: begin
                w_req  = 1'b1;
                w_we   = (w_dec.cls == ClsStore);
                w_addr = r_alu;
                if (mem_ready) begin
                    w_state_d = (w_dec.cls == ClsStore) ? StFetch : StWb;
                    w_retire  = (w_dec.cls == ClsStore);
                end
            end
            StWb: begin
                w_state_d = StFetch;
                w_retire  = 1'b1;
            end
            StHalt:  w_state_d = StHalt;
            default: w_state_d = StFetch;
        endcase
    end

    // r_a/r_b/r_imm/r_alu are held across MEM so address and store data stay stable in waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StFetch && mem_ready) r_ir <= mem_rdata[31:0];
            if (r_state == StDecode) begin
                r_a   <= w_rs1_data;
                r_b   <= w_rs2_data;
                r_imm <= w_imm;
            end
            if (r_state == StExec) r_alu <= w_alu_res;
            if (r_state == StMem && mem_ready) r_mdr <= mem_rdata;
            if (w_retire) r_pc <= w_pc_next;
        end
    end

    assign mem_req   = w_req & ~reset;
    assign mem_we    = w_we;
    assign mem_addr  = w_addr;
    assign mem_wdata = r_b;
    assign pc        = r_pc;
    assign retire    = w_retire & ~reset;
    assign halt      = (r_state == StHalt) & ~reset;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: an XLEN=32 core at RESET_PC=0x100 and an XLEN=64 core at 0,
// each with a wait-state memory model and a store scoreboard.
module tb_multicycle_datapath;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } st_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // core A: XLEN=32, RESET_PC=0x100
    logic        reset_a, req_a, we_a, ready_a, retire_a, halt_a;
    logic [31:0] addr_a, wdata_a, rdata_a, pc_a;
    // core B: XLEN=64, RESET_PC=0
    logic        reset_b, req_b, we_b, ready_b, retire_b, halt_b;
    logic [63:0] addr_b, wdata_b, rdata_b, pc_b;

    multicycle_datapath #(.XLEN(32), .RESET_PC(32'h100)) u_dut_a (
        .clk(clk), .reset(reset_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_ready(ready_a), .mem_rdata(rdata_a), .pc(pc_a),
        .retire(retire_a), .halt(halt_a)
    );

    multicycle_datapath #(.XLEN(64), .RESET_PC(64'h0)) u_dut_b (
        .clk(clk), .reset(reset_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .mem_ready(ready_b), .mem_rdata(rdata_b), .pc(pc_b),
        .retire(retire_b), .halt(halt_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lw(input int rd, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input int rs2, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_br(input logic [2:0] f3, input int rs1, input int rs2,
                                           input int imm);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
    endfunction

    localparam logic [31:0] Ecall = 32'h0000_0073;

    // Memory models
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    st_t         exp_a[$], exp_b[$];
    int          cnt_a = 0, cnt_b = 0, stable_err_a = 0, data_waits_a = 0;
    logic        force_a = 1'b0;
    logic [31:0] cap_addr_a, cap_wdata_a;
    logic        cap_we_a;

    // Data addresses below 0x40 get 3 wait states; force_a stalls fetches from 0x104 up.
    function automatic int waits_a(input logic [31:0] addr, input logic we, input logic frc);
        if (frc && !we && addr >= 32'h104) return 100000;
        return (addr < 32'h40) ? 3 : 0;
    endfunction

    always @(negedge clk) begin
        if (req_a) begin
            if (cnt_a == 0) begin
                cap_addr_a  = addr_a;
                cap_we_a    = we_a;
                cap_wdata_a = wdata_a;
            end else if (addr_a !== cap_addr_a || we_a !== cap_we_a ||
                         (we_a && wdata_a !== cap_wdata_a)) begin
                stable_err_a++;
            end
            if (cnt_a >= waits_a(addr_a, we_a, force_a)) begin
                ready_a = 1'b1;
                cnt_a   = 0;
                if (we_a) begin
                    if (exp_a.size() == 0) begin
                        check_eq("a_store_unexpected", 64'(exp_a.size()), 64'd1);
                    end else begin
                        st_t e;
                        e = exp_a.pop_front();
                        check_eq("a_store_addr", {32'b0, addr_a}, e.addr);
                        check_eq("a_store_data", {32'b0, wdata_a}, e.data);
                    end
                    mem_a[addr_a[9:2]] = wdata_a;
                end else begin
                    rdata_a = mem_a[addr_a[9:2]];
                end
            end else begin
                ready_a = 1'b0;
                if (addr_a < 32'h40) data_waits_a++;
                cnt_a++;
            end
        end else begin
            ready_a = 1'b0;
            cnt_a   = 0;
        end
    end

    always @(negedge clk) begin
        if (req_b) begin
            ready_b = 1'b1;
            if (we_b) begin
                if (exp_b.size() == 0) begin
                    check_eq("b_store_unexpected", 64'(exp_b.size()), 64'd1);
                end else begin
                    st_t e;
                    e = exp_b.pop_front();
                    check_eq("b_store_addr", addr_b, e.addr);
                    check_eq("b_store_data", wdata_b, e.data);
                end
                mem_b[addr_b[9:2]] = wdata_b[31:0];
            end else begin
                rdata_b = {32'b0, mem_b[addr_b[9:2]]};
            end
        end else begin
            ready_b = 1'b0;
        end
    end

    // Retire timestamps per pc, and the fetch address that follows each retire.
    int          ret_cyc_a [256];
    int          ret_cyc_b [256];
    logic [31:0] br_next_b [256];
    logic        prev_ret_b = 1'b0;
    logic [7:0]  prev_pc_b;

    always @(negedge clk) begin
        #1;
        if (retire_a) ret_cyc_a[pc_a[9:2]] = cyc;
        if (retire_b) ret_cyc_b[pc_b[9:2]] = cyc;
        if (prev_ret_b) br_next_b[prev_pc_b] = addr_b[31:0];
        prev_ret_b = retire_b;
        prev_pc_b  = pc_b[9:2];
    end

    task automatic push_a(input logic [31:0] addr, input logic [31:0] data);
        st_t e;
        e.addr = {32'b0, addr};
        e.data = {32'b0, data};
        exp_a.push_back(e);
    endtask
    task automatic push_b(input logic [63:0] addr, input logic [63:0] data);
        st_t e;
        e.addr = addr;
        e.data = data;
        exp_b.push_back(e);
    endtask

    task automatic wait_halt_b(input string tag);
        for (int i = 0; i < 2000 && !halt_b; i++) @(posedge clk);
        #1;
        check_eq(tag, 64'(halt_b), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_req, any_ret;
        reset_a = 1'b1;
        reset_b = 1'b1;
        ready_a = 1'b0;
        ready_b = 1'b0;
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i]     = Ecall;
            mem_b[i]     = Ecall;
            ret_cyc_a[i] = -1;
            ret_cyc_b[i] = -1;
            br_next_b[i] = '0;
        end

        // ---- Core A program at 0x100 ----
        for (int i = 1; i < 32; i++) begin
            mem_a[(32'h100 + 4 * (i - 1)) >> 2] = enc_sw(i, 0, 32'h200 + 4 * i);
            push_a(32'h200 + 4 * i, 32'h0);
        end
        mem_a[32'h17C >> 2] = enc_addi(1, 0, 5);
        mem_a[32'h180 >> 2] = enc_addi(2, 0, 7);
        mem_a[32'h184 >> 2] = enc_r(7'h00, 3'b000, 3, 1, 2);
        mem_a[32'h188 >> 2] = enc_sw(3, 0, 8);           push_a(8, 12);
        mem_a[32'h18C >> 2] = enc_lw(4, 0, 8);
        mem_a[32'h190 >> 2] = enc_sw(4, 0, 12);          push_a(12, 12);
        mem_a[32'h194 >> 2] = enc_addi(0, 0, 9);
        mem_a[32'h198 >> 2] = enc_sw(0, 0, 16);          push_a(16, 0);
        mem_a[32'h19C >> 2] = enc_addi(1, 0, 1);
        mem_a[32'h1A0 >> 2] = enc_r(7'h20, 3'b000, 5, 0, 1);
        mem_a[32'h1A4 >> 2] = enc_sw(5, 0, 20);          push_a(20, 32'hFFFF_FFFF);
        mem_a[32'h1A8 >> 2] = enc_r(7'h00, 3'b010, 6, 5, 1);
        mem_a[32'h1AC >> 2] = enc_sw(6, 0, 24);          push_a(24, 1);
        mem_a[32'h1B0 >> 2] = enc_r(7'h00, 3'b111, 7, 3, 2);
        mem_a[32'h1B4 >> 2] = enc_r(7'h00, 3'b110, 8, 3, 2);
        mem_a[32'h1B8 >> 2] = enc_sw(7, 0, 28);          push_a(28, 4);
        mem_a[32'h1BC >> 2] = enc_sw(8, 0, 32);          push_a(32, 15);
        mem_a[32'h1C0 >> 2] = enc_r(7'h00, 3'b010, 9, 1, 5);
        mem_a[32'h1C4 >> 2] = enc_sw(9, 0, 36);          push_a(36, 0);
        mem_a[32'h1C8 >> 2] = Ecall;

        repeat (3) @(posedge clk);
        #1;
        check_eq("a_rst_req", 64'(req_a), 64'd0);
        check_eq("a_rst_retire", 64'(retire_a), 64'd0);
        check_eq("a_rst_halt", 64'(halt_a), 64'd0);
        check_eq("b_rst_req", 64'(req_b), 64'd0);
        reset_a = 1'b0;
        @(negedge clk);
        check_eq("a_first_fetch_req", 64'(req_a), 64'd1);
        check_eq("a_first_fetch_addr", {32'b0, addr_a}, 64'h100);
        check_eq("a_first_fetch_we", 64'(we_a), 64'd0);

        for (int i = 0; i < 3000 && !halt_a; i++) @(posedge clk);
        #1;
        check_eq("a_halt", 64'(halt_a), 64'd1);
        check_eq("a_lat_sw0", 64'(ret_cyc_a[32'h17C >> 2] - ret_cyc_a[32'h178 >> 2]), 64'd4);
        check_eq("a_lat_addi", 64'(ret_cyc_a[32'h180 >> 2] - ret_cyc_a[32'h17C >> 2]), 64'd4);
        check_eq("a_lat_add", 64'(ret_cyc_a[32'h184 >> 2] - ret_cyc_a[32'h180 >> 2]), 64'd4);
        check_eq("a_lat_sw_wait", 64'(ret_cyc_a[32'h188 >> 2] - ret_cyc_a[32'h184 >> 2]), 64'd7);
        check_eq("a_lat_lw_wait", 64'(ret_cyc_a[32'h18C >> 2] - ret_cyc_a[32'h188 >> 2]), 64'd8);
        check_eq("a_wait_stable", 64'(stable_err_a), 64'd0);
        check_eq("a_data_waits", 64'(data_waits_a), 64'd27);
        check_eq("a_ecall_no_retire", 64'(ret_cyc_a[32'h1C8 >> 2]), 64'hFFFF_FFFF_FFFF_FFFF);

        any_req = 1'b0;
        any_ret = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            any_req |= req_a;
            any_ret |= retire_a;
        end
        check_eq("a_halt_no_req", 64'(any_req), 64'd0);
        check_eq("a_halt_no_retire", 64'(any_ret), 64'd0);
        check_eq("a_halt_held", 64'(halt_a), 64'd1);
        check_eq("a_halt_pc", {32'b0, pc_a}, 64'h1C8);
        check_eq("a_sb_empty", 64'(exp_a.size()), 64'd0);

        // Reset exits HALT and clears registers (x1 stored as 0); then reset mid-FETCH.
        push_a(32'h204, 32'h0);
        force_a = 1'b1;
        @(posedge clk);
        #1 reset_a = 1'b1;
        @(posedge clk);
        #1 reset_a = 1'b0;
        check_eq("a_halt_cleared", 64'(halt_a), 64'd0);
        for (int i = 0; i < 100 && !(req_a && addr_a == 32'h104); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check_eq("a_stall_req", 64'(req_a), 64'd1);
        check_eq("a_stall_addr", {32'b0, addr_a}, 64'h104);
        reset_a = 1'b1;
        #1;
        check_eq("a_mid_rst_req", 64'(req_a), 64'd0);
        @(posedge clk);
        #1 reset_a = 1'b0;
        force_a = 1'b0;
        @(negedge clk);
        check_eq("a_refetch_req", 64'(req_a), 64'd1);
        check_eq("a_refetch_addr", {32'b0, addr_a}, 64'h100);
        check_eq("a_refetch_we", 64'(we_a), 64'd0);
        @(posedge clk);
        #1 reset_a = 1'b1;
        check_eq("a_sb_empty2", 64'(exp_a.size()), 64'd0);

        // ---- Core B (XLEN=64) run 1: beq backwards ----
        mem_b[0] = enc_addi(1, 0, 1);
        mem_b[1] = enc_r(7'h20, 3'b000, 5, 0, 1);
        mem_b[2] = enc_sw(5, 0, 32'h300);                push_b(64'h300, '1);
        mem_b[3] = enc_addi(0, 0, 9);
        mem_b[4] = enc_sw(0, 0, 32'h308);                push_b(64'h308, 64'h0);
        mem_b[5] = enc_br(3'b000, 0, 0, 12);
        mem_b[6] = enc_sw(1, 0, 32'h310);                push_b(64'h310, 64'h1);
        mem_b[7] = Ecall;
        mem_b[8] = enc_br(3'b000, 1, 1, -8);
        @(posedge clk);
        #1 reset_b = 1'b0;
        wait_halt_b("b1_halt");
        check_eq("b1_beq_fwd_next", {32'b0, br_next_b[5]}, 64'h20);
        check_eq("b1_beq_back_next", {32'b0, br_next_b[8]}, 64'h18);
        check_eq("b1_sb_empty", 64'(exp_b.size()), 64'd0);

        // ---- Core B run 2: bne not taken, branch latency ----
        #1 reset_b = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mem_b[i]     = Ecall;
            br_next_b[i] = '0;
            ret_cyc_b[i] = -1;
        end
        mem_b[0] = enc_addi(1, 0, 1);
        mem_b[1] = enc_br(3'b000, 0, 0, 28);
        mem_b[8] = enc_br(3'b001, 1, 1, 8);
        mem_b[9] = enc_sw(1, 0, 32'h318);                push_b(64'h318, 64'h1);
        repeat (2) @(posedge clk);
        #1 reset_b = 1'b0;
        wait_halt_b("b2_halt");
        check_eq("b2_bne_next", {32'b0, br_next_b[8]}, 64'h24);
        check_eq("b2_lat_branch", 64'(ret_cyc_b[8] - ret_cyc_b[1]), 64'd3);
        check_eq("b2_halt_pc", pc_b, 64'h28);
        check_eq("b2_sb_empty", 64'(exp_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  unified memory request valid.
REQ-006 SHALL have port mem_we  output  1  1 = store, 0 = load/fetch.
REQ-007 SHALL have port mem_addr  output  XLEN  byte address of the request.
REQ-008 SHALL have port mem_wdata  output  XLEN  store data.
REQ-009 SHALL have port mem_ready  input  1  memory completes the request this cycle.
REQ-010 SHALL have port mem_rdata  input  XLEN  read data, valid when mem_ready=1.
REQ-011 SHALL have port pc  output  XLEN  address of the instruction in flight.
REQ-012 SHALL have port retire  output  1  one-cycle pulse when an instruction completes.
REQ-013 SHALL have port halt  output  1  core stopped; held until reset.

Function
REQ-014 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready, latch mem_rdata into IR, go DECODE.
REQ-016 DECODE: read rs1/rs2, generate immediate, go EXEC.
REQ-017 EXEC: R-type (add, sub, and, or, slt), addi -> WB; lw/sw -> MEM with address rs1+imm; beq/bne -> FETCH.
REQ-018 Taken branch: pc <= pc+imm (B-type, sign-extended to XLEN); otherwise, and for every other instruction, pc <= pc+4.
REQ-019 MEM: mem_req=1, mem_addr=ALU result, mem_we=1 for sw with mem_wdata=rs2; on mem_ready, lw -> WB (latch mem_rdata), sw -> FETCH.
REQ-020 WB: write rd with ALU result or load data, go FETCH.
REQ-021 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0; wait states are unbounded.
REQ-022 mem_req SHALL be 0 in DECODE, EXEC, WB and HALT.
REQ-023 ecall (opcode 1110011) and any unsupported opcode SHALL go from EXEC to HALT without retiring; halt=1 in HALT; pc frozen.
REQ-024 Latency with zero-wait memory: R/I-type 4 cycles, lw 5, sw 4, branch 3; each wait cycle adds 1.
REQ-025 retire SHALL pulse in the cycle the FSM leaves WB, leaves MEM for sw, or leaves EXEC for a branch.
REQ-026 Register x0 SHALL read 0; writes to x0 are discarded.
REQ-027 All arithmetic SHALL be modulo 2^XLEN; slt is signed; I/S-type immediates are sign-extended to XLEN.
REQ-028 mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-029 While reset=1 at a clock edge: state <= FETCH, pc <= RESET_PC, IR <= 0, all 32 registers <= 0.
REQ-030 mem_req, retire and halt SHALL be 0 in any cycle where reset=1.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request; the first post-reset request is a fetch at RESET_PC.
REQ-032 Reset SHALL be the only exit from HALT.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, opcode constants, funct3/funct7 codes and ALU operation codes.
REQ-034 The 32xXLEN register file SHALL be the sub-module riscv_regfile (two combinational read ports, one synchronous write port).

Verification
REQ-035 Reset with RESET_PC=0x100 -> first fetch at mem_addr=0x100 one cycle after reset falls; x1..x31 read 0.
REQ-036 addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 with zero-wait memory -> x3=12, retire pulses every 4 cycles.
REQ-037 sw x3,8(x0) then lw x4,8(x0) with 3 wait cycles per access -> store at addr 8 with wdata 12, stable across the wait cycles; x4=12.
REQ-038 beq x1,x1,-8 at pc 0x20 -> next fetch at 0x18; bne x1,x1,+8 -> next fetch at 0x24.
REQ-039 Word 0x00000073 (ecall) -> halt=1, mem_req=0 permanently; reset asserted mid-FETCH -> refetch at RESET_PC.
REQ-040 addi x0,x0,9 -> x0 still reads 0; sub x5,x0,x1 with x1=1 -> x5 = all ones (XLEN=32 and XLEN=64 runs).
